// File: rtl/cam_power_sequencer.sv
// Camera/MIPI power sequencer: PLL settle, ordered pin release, CPU shutdown/restart, level IRQ.
// Outputs registered from next state (1-cycle); CAM_SEQ_PLL_MONITOR_EN enables lock-loss abort.
module cam_power_sequencer #(
  parameter int T_SETTLE = 8,
  parameter int T_PWDN   = 4,
  parameter int T_RST    = 6,
  parameter int CNT_W    = 16
) (
  input  logic       clk_clk,
  input  logic       rst_reset_n,
  input  logic       pll_lock_states,
  input  logic       cpu_pwdn_req,
  input  logic       cpu_restart,
  input  logic       irq_ack,
  output logic       camera_pwdn_n,
  output logic       mipi_reset_n,
  output logic       seq_ready,
  output logic [2:0] seq_state,
  output logic       seq_irq_n,
  output logic       lock_lost
);

  localparam logic [2:0] S_RESET     = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_SETTLE    = 3'd2;
  localparam logic [2:0] S_PWR_UP    = 3'd3;
  localparam logic [2:0] S_RST_REL   = 3'd4;
  localparam logic [2:0] S_READY     = 3'd5;
  localparam logic [2:0] S_SHUTDOWN  = 3'd6;
  localparam logic [2:0] S_OFF       = 3'd7;

  localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(T_SETTLE - 1);
  localparam logic [CNT_W-1:0] LD_PWDN   = CNT_W'(T_PWDN - 1);
  localparam logic [CNT_W-1:0] LD_RST    = CNT_W'(T_RST - 1);

  logic [1:0]       sync;
  logic             lock_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       st_nxt;
  logic             cnt_zero;
  logic             abort;
  logic             restart;

  assign lock_s   = sync[1];
  assign cnt_zero = (cnt == '0);
  assign restart  = cpu_restart && (seq_state != S_RESET);

`ifdef CAM_SEQ_PLL_MONITOR_EN
  // Lock-loss only matters once the pins have started moving.
  assign abort = !restart && !lock_s &&
                 ((seq_state == S_PWR_UP) || (seq_state == S_RST_REL) ||
                  (seq_state == S_READY)  || (seq_state == S_SHUTDOWN));
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], pll_lock_states};
    end
  end

  always_comb begin
    st_nxt  = seq_state;
    cnt_nxt = cnt_zero ? cnt : cnt - 1'b1;
    if (seq_state == S_RESET) begin
      st_nxt = S_WAIT_LOCK;
    end else if (restart || abort) begin
      st_nxt = S_WAIT_LOCK;
    end else begin
      case (seq_state)
        S_WAIT_LOCK: begin
          if (lock_s) begin
            st_nxt  = S_SETTLE;
            cnt_nxt = LD_SETTLE;
          end
        end
        S_SETTLE: begin
          if (!lock_s) begin
            st_nxt = S_WAIT_LOCK;
          end else if (cnt_zero) begin
            st_nxt  = S_PWR_UP;
            cnt_nxt = LD_PWDN;
          end
        end
        S_PWR_UP: begin
          if (cnt_zero) begin
            st_nxt  = S_RST_REL;
            cnt_nxt = LD_RST;
          end
        end
        S_RST_REL: begin
          if (cnt_zero) st_nxt = S_READY;
        end
        S_READY: begin
          if (cpu_pwdn_req) begin
            st_nxt  = S_SHUTDOWN;
            cnt_nxt = LD_PWDN;
          end
        end
        S_SHUTDOWN: begin
          if (cnt_zero) st_nxt = S_OFF;
        end
        S_OFF: begin
          if (!cpu_pwdn_req) st_nxt = S_WAIT_LOCK;
        end
        default: st_nxt = S_WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      seq_state     <= S_RESET;
      cnt           <= '0;
      camera_pwdn_n <= 1'b0;
      mipi_reset_n  <= 1'b0;
      seq_ready     <= 1'b0;
      seq_irq_n     <= 1'b1;
    end else begin
      seq_state     <= st_nxt;
      cnt           <= cnt_nxt;
      camera_pwdn_n <= (st_nxt == S_PWR_UP) || (st_nxt == S_RST_REL) ||
                       (st_nxt == S_READY)  || (st_nxt == S_SHUTDOWN);
      mipi_reset_n  <= (st_nxt == S_RST_REL) || (st_nxt == S_READY);
      seq_ready     <= (st_nxt == S_READY);
      // An assert event beats a coincident acknowledge.
      if (((st_nxt == S_READY) && (seq_state != S_READY)) || abort) begin
        seq_irq_n <= 1'b0;
      end else if (irq_ack) begin
        seq_irq_n <= 1'b1;
      end
    end
  end

`ifdef CAM_SEQ_PLL_MONITOR_EN
  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      lock_lost <= 1'b0;
    end else if (restart) begin
      lock_lost <= 1'b0;
    end else if (abort) begin
      lock_lost <= 1'b1;
    end
  end
`else
  assign lock_lost = 1'b0;
`endif

endmodule

// File: tb/tb_cam_power_sequencer.sv
// Bench for cam_power_sequencer: directed vector table, hand-written corner sequences, random vs. model.
module tb_cam_power_sequencer;
  localparam int T_SETTLE = 8;
  localparam int T_PWDN   = 4;
  localparam int T_RST    = 6;
`ifdef CAM_SEQ_PLL_MONITOR_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic lock = 1'b0, pwdn = 1'b0, rs = 1'b0, ak = 1'b0;
  logic cam, mipi, rdy, irq_n, ll;
  logic [2:0] st;

  cam_power_sequencer #(.T_SETTLE(T_SETTLE), .T_PWDN(T_PWDN), .T_RST(T_RST), .CNT_W(16)) dut (
    .clk_clk(clk), .rst_reset_n(rst_n), .pll_lock_states(lock), .cpu_pwdn_req(pwdn),
    .cpu_restart(rs), .irq_ack(ak), .camera_pwdn_n(cam), .mipi_reset_n(mipi),
    .seq_ready(rdy), .seq_state(st), .seq_irq_n(irq_n), .lock_lost(ll)
  );

  int tests = 0;
  int fails = 0;

  function automatic logic [7:0] pk(int s, bit c, bit m, bit r, bit i, bit l);
    logic [2:0] s3;
    s3 = s[2:0];
    return {l, i, r, m, c, s3};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {ll, irq_n, rdy, mipi, cam, st};
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {ll,irq_n,rdy,mipi,cam,st}=%b required %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state plus cycles spent in it, lock seen through a 2-deep delay queue.
  int m_st, m_dwell;
  bit m_ll, m_irq_n;
  bit lq[$];

  task automatic model_reset();
    m_st = 0; m_dwell = 0; m_ll = 0; m_irq_n = 1;
    lq = {1'b0, 1'b0};
  endtask

  function automatic logic [7:0] m_out();
    bit c, m;
    c = (m_st >= 3) && (m_st <= 6);
    m = (m_st == 4) || (m_st == 5);
    return pk(m_st, c, m, m_st == 5, m_irq_n, m_ll);
  endfunction

  task automatic model_step(bit lk, bit pw, bit rq, bit ackq);
    bit ls, ab;
    int nxt;
    ls = lq.pop_front();
    lq.push_back(lk);
    ab = 0;
    nxt = m_st;
    if (m_st == 0) nxt = 1;
    else if (rq) begin nxt = 1; m_ll = 0; end
    else if (MON && m_st >= 3 && m_st <= 6 && !ls) begin nxt = 1; m_ll = 1; ab = 1; end
    else begin
      case (m_st)
        1: if (ls) nxt = 2;
        2: nxt = !ls ? 1 : (m_dwell == T_SETTLE ? 3 : 2);
        3: if (m_dwell == T_PWDN) nxt = 4;
        4: if (m_dwell == T_RST) nxt = 5;
        5: if (pw) nxt = 6;
        6: if (m_dwell == T_PWDN) nxt = 7;
        7: if (!pw) nxt = 1;
        default: nxt = 1;
      endcase
    end
    if ((nxt == 5 && m_st != 5) || ab) m_irq_n = 0;
    else if (ackq) m_irq_n = 1;
    m_dwell = (nxt != m_st) ? 1 : m_dwell + 1;
    m_st = nxt;
  endtask

  task automatic tick();
    bit lk, pw, rq, aq;
    lk = lock; pw = pwdn; rq = rs; aq = ak;
    @(posedge clk);
    #1;
    model_step(lk, pw, rq, aq);
    chk("model", dut_vec(), m_out());
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    int n;
    bit lk, pw, rs, ak;
    logic [7:0] exp;
    string name;
  } vec_t;

  vec_t vq[$];

  initial begin
    model_reset();
    lock = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", dut_vec(), pk(0, 0, 0, 0, 1, 0));
    rst_n = 1'b1;

    vq.push_back('{1, 1, 0, 0, 0, pk(1, 0, 0, 0, 1, 0), "edge1_wait_lock"});
    vq.push_back('{2, 1, 0, 0, 0, pk(2, 0, 0, 0, 1, 0), "edge3_settle"});
    vq.push_back('{7, 1, 0, 0, 0, pk(2, 0, 0, 0, 1, 0), "edge10_settle_end"});
    vq.push_back('{1, 1, 0, 0, 0, pk(3, 1, 0, 0, 1, 0), "edge11_cam_rise"});
    vq.push_back('{3, 1, 0, 0, 0, pk(3, 1, 0, 0, 1, 0), "edge14_pwr_up"});
    vq.push_back('{1, 1, 0, 0, 0, pk(4, 1, 1, 0, 1, 0), "edge15_mipi_rise"});
    vq.push_back('{5, 1, 0, 0, 0, pk(4, 1, 1, 0, 1, 0), "edge20_rst_rel"});
    vq.push_back('{1, 1, 0, 0, 1, pk(5, 1, 1, 1, 0, 0), "edge21_ready_ack_coincide"});
    vq.push_back('{2, 1, 0, 0, 0, pk(5, 1, 1, 1, 0, 0), "irq_held"});
    vq.push_back('{1, 1, 0, 0, 1, pk(5, 1, 1, 1, 1, 0), "irq_ack_release"});
    vq.push_back('{1, 1, 1, 0, 0, pk(6, 1, 0, 0, 1, 0), "shutdown_mipi_fall"});
    vq.push_back('{3, 1, 0, 0, 0, pk(6, 1, 0, 0, 1, 0), "shutdown_dwell"});
    vq.push_back('{1, 1, 0, 0, 0, pk(7, 0, 0, 0, 1, 0), "off_cam_fall"});
    vq.push_back('{1, 1, 0, 0, 0, pk(1, 0, 0, 0, 1, 0), "off_to_wait_lock"});
    vq.push_back('{1, 1, 0, 0, 0, pk(2, 0, 0, 0, 1, 0), "resettle"});
    vq.push_back('{8, 1, 0, 0, 0, pk(3, 1, 0, 0, 1, 0), "repower"});
    vq.push_back('{4, 1, 0, 0, 0, pk(4, 1, 1, 0, 1, 0), "rst_rel_again"});
    vq.push_back('{1, 1, 0, 1, 0, pk(1, 0, 0, 0, 1, 0), "restart_in_rst_rel"});
    vq.push_back('{1, 1, 0, 0, 0, pk(2, 0, 0, 0, 1, 0), "restart_settle"});
    vq.push_back('{8, 1, 0, 0, 0, pk(3, 1, 0, 0, 1, 0), "restart_pwr_up"});
    vq.push_back('{4, 1, 0, 0, 0, pk(4, 1, 1, 0, 1, 0), "restart_rst_rel"});
    vq.push_back('{6, 1, 0, 0, 0, pk(5, 1, 1, 1, 0, 0), "restart_ready"});

    foreach (vq[i]) begin
      lock = vq[i].lk; pwdn = vq[i].pw; rs = vq[i].rs; ak = vq[i].ak;
      ticks(vq[i].n);
      chk(vq[i].name, dut_vec(), vq[i].exp);
    end
    rs = 0; ak = 0; pwdn = 0;

    // Lock glitch of 3 cycles during SETTLE restarts the full settle.
    rs = 1; tick(); rs = 0;
    tick(); ticks(2);
    chk("glitch_pre", dut_vec(), pk(2, 0, 0, 0, 0, 0));
    lock = 0; ticks(2);
    chk("glitch_sync_delay", dut_vec(), pk(2, 0, 0, 0, 0, 0));
    tick();
    chk("glitch_wait_lock", dut_vec(), pk(1, 0, 0, 0, 0, 0));
    lock = 1; ticks(2);
    chk("glitch_relock_delay", dut_vec(), pk(1, 0, 0, 0, 0, 0));
    tick();
    chk("glitch_resettle", dut_vec(), pk(2, 0, 0, 0, 0, 0));
    ticks(7);
    chk("glitch_full_settle", dut_vec(), pk(2, 0, 0, 0, 0, 0));
    tick();
    chk("glitch_pwr_up", dut_vec(), pk(3, 1, 0, 0, 0, 0));
    ticks(10);
    chk("glitch_ready", dut_vec(), pk(5, 1, 1, 1, 0, 0));
    ak = 1; tick(); ak = 0;

    // Lock loss in READY.
    lock = 0; ticks(2);
    chk("lockloss_sync_delay", dut_vec(), pk(5, 1, 1, 1, 1, 0));
    tick();
    chk("lockloss_ready", dut_vec(), MON ? pk(1, 0, 0, 0, 0, 1) : pk(5, 1, 1, 1, 1, 0));
    rs = 1; tick(); rs = 0;
    chk("lockloss_restart_clears", dut_vec(), pk(1, 0, 0, 0, MON ? 1'b0 : 1'b1, 0));
    lock = 1;

    // Randomized run against the model, with one asynchronous reset in the middle.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) < 5) lock = ~lock;
      if ($urandom_range(0, 99) < 4) pwdn = ~pwdn;
      rs = ($urandom_range(0, 99) < 1);
      ak = ($urandom_range(0, 99) < 10);
      if (c == 2000) begin
        rst_n = 0;
        #1;
        chk("async_reset", dut_vec(), pk(0, 0, 0, 0, 1, 0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
